hl_reset_sequencer: RTL and testbench

- Parametrised power-up and reset sequencer for the Hermes Lite board wrappers, running on rstclk.
- Waits for a stable IF PLL lock, then selects the AD9866 clock source: external AD9866clk, or the internal test clock when no expansion board is present.
- Sequences PHY reset, then AD9866 reset, then staggered release of NR receiver resets.
- Flags ready to the core and restarts the sequence on lock loss or expansion change.

---
 rtl/hl_reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_hl_reset_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hl_reset_sequencer.sv
// Power-up / reset sequencer for the Hermes Lite board wrappers (rstclk domain).
// Define HL_CLKMON_EN to build the AD9866 heartbeat clock monitor.
module hl_reset_sequencer #(
    parameter int NR          = 3,
    parameter int CW          = 16,
    parameter int LOCK_WAIT   = 1024,
    parameter int PHY_RST_CYC = 256,
    parameter int AD_RST_CYC  = 64,
    parameter int STAGGER     = 16,
    parameter int HB_TIMEOUT  = 8
) (
    input  logic          rstclk,
    input  logic          extreset,
    input  logic          pll_locked,
    input  logic          exp_present,
    input  logic          ad9866_hb,
    output logic          clk_sel,
    output logic          phy_reset_n,
    output logic          ad9866_rst_n,
    output logic [NR-1:0] rx_rst,
    output logic          ready,
    output logic          clk_fault
);

    typedef enum logic [2:0] {S_IDLE, S_LOCK, S_PHY, S_AD, S_RX, S_RUN} state_t;

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_WAIT - 1);
    localparam logic [CW-1:0] PHY_LAST  = CW'(PHY_RST_CYC - 1);
    localparam logic [CW-1:0] AD_LAST   = CW'(AD_RST_CYC - 1);
    localparam logic [CW-1:0] RX_LAST   = CW'(NR * STAGGER - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    lock_ff;
    logic [1:0]    exp_ff;
    logic          lock_sync;
    logic          exp_sync;
    logic          exp_prev;
    logic          exp_edge;
    logic          hb_fault_evt;
    logic          restart;
    logic [NR-1:0] rx_hit;

    // Plain 2-FF synchronisers; deliberately not reset.
    always_ff @(posedge rstclk) begin
        lock_ff <= {lock_ff[0], pll_locked};
        exp_ff  <= {exp_ff[0], exp_present};
    end

    assign lock_sync = lock_ff[1];
    assign exp_sync  = exp_ff[1];
    assign exp_edge  = exp_sync ^ exp_prev;
    assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    for (genvar i = 0; i < NR; i++) begin : g_rx
        assign rx_hit[i] = (cnt == CW'((i + 1) * STAGGER - 1));
    end

    // Expansion edges only matter once the clock choice has been committed.
    assign restart = (state != S_IDLE) &&
                     (!lock_sync || hb_fault_evt ||
                      (exp_edge && state != S_LOCK));

`ifdef HL_CLKMON_EN
    localparam int HW = $clog2(HB_TIMEOUT) + 1;
    localparam logic [HW-1:0] HB_LAST = HW'(HB_TIMEOUT - 1);

    logic [1:0]    hb_ff;
    logic          hb_prev;
    logic          hb_edge;
    logic          hb_mon;
    logic [HW-1:0] hb_cnt;

    always_ff @(posedge rstclk) begin
        hb_ff <= {hb_ff[0], ad9866_hb};
    end

    assign hb_edge = hb_ff[1] ^ hb_prev;
    // Once faulted the clock is pinned internal, so further timeouts are moot.
    assign hb_mon  = (state != S_IDLE) && exp_sync && !clk_sel && !clk_fault;
    assign hb_fault_evt = hb_mon && !hb_edge && (hb_cnt == HB_LAST);

    always_ff @(posedge rstclk) begin
        if (extreset) begin
            hb_prev   <= 1'b0;
            hb_cnt    <= '0;
            clk_fault <= 1'b0;
        end else begin
            hb_prev <= hb_ff[1];
            if (!hb_mon || hb_edge)
                hb_cnt <= '0;
            else if (hb_cnt != HB_LAST)
                hb_cnt <= hb_cnt + 1'b1;
            if (hb_fault_evt)
                clk_fault <= 1'b1;
        end
    end
`else
    logic unused_hb;
    assign unused_hb    = ad9866_hb;
    assign hb_fault_evt = 1'b0;
    assign clk_fault    = 1'b0;
`endif

    always_ff @(posedge rstclk) begin
        if (extreset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            exp_prev     <= 1'b0;
            clk_sel      <= 1'b1;
            phy_reset_n  <= 1'b0;
            ad9866_rst_n <= 1'b0;
            rx_rst       <= '1;
            ready        <= 1'b0;
        end else begin
            exp_prev <= exp_sync;
            if (restart) begin
                // clk_sel intentionally holds; it is only re-chosen on S_LOCK exit.
                state        <= S_LOCK;
                cnt          <= '0;
                phy_reset_n  <= 1'b0;
                ad9866_rst_n <= 1'b0;
                rx_rst       <= '1;
                ready        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_LOCK;
                        cnt   <= '0;
                    end
                    S_LOCK: begin
                        if (cnt == LOCK_LAST) begin
                            clk_sel <= ~exp_sync | clk_fault;
                            cnt     <= '0;
                            state   <= S_PHY;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_PHY: begin
                        if (cnt == PHY_LAST) begin
                            phy_reset_n <= 1'b1;
                            cnt         <= '0;
                            state       <= S_AD;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_AD: begin
                        if (cnt == AD_LAST) begin
                            ad9866_rst_n <= 1'b1;
                            cnt          <= '0;
                            state        <= S_RX;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_RX: begin
                        rx_rst <= rx_rst & ~rx_hit;
                        if (cnt == RX_LAST) begin
                            ready <= 1'b1;
                            cnt   <= '0;
                            state <= S_RUN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_RUN: begin
                        ready <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hl_reset_sequencer.sv
// Directed bench for hl_reset_sequencer; builds the heartbeat scenario when HL_CLKMON_EN is defined.
module tb_hl_reset_sequencer;
    localparam int NR = 3;

    logic          rstclk = 1'b0;
    logic          extreset = 1'b1;
    logic          pll_locked = 1'b0;
    logic          exp_present = 1'b0;
    logic          ad9866_hb = 1'b0;
    logic          clk_sel, phy_reset_n, ad9866_rst_n, ready, clk_fault;
    logic [NR-1:0] rx_rst;

    int n_chk = 0;
    int n_pass = 0;
    int ec = 0;
    bit hb_run = 1'b1;

    hl_reset_sequencer #(
        .NR(NR), .CW(16), .LOCK_WAIT(8), .PHY_RST_CYC(4),
        .AD_RST_CYC(4), .STAGGER(2), .HB_TIMEOUT(8)
    ) dut (
        .rstclk      (rstclk),
        .extreset    (extreset),
        .pll_locked  (pll_locked),
        .exp_present (exp_present),
        .ad9866_hb   (ad9866_hb),
        .clk_sel     (clk_sel),
        .phy_reset_n (phy_reset_n),
        .ad9866_rst_n(ad9866_rst_n),
        .rx_rst      (rx_rst),
        .ready       (ready),
        .clk_fault   (clk_fault)
    );

    always #5 rstclk = ~rstclk;

    always @(negedge rstclk) if (hb_run) ad9866_hb = ~ad9866_hb;

    task automatic tick();
        @(posedge rstclk);
        #1;
        ec++;
    endtask

    task automatic run_to(input int n);
        while (ec < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset(input bit lk, input bit ex);
        extreset = 1'b1;
        pll_locked = lk;
        exp_present = ex;
        repeat (4) tick();
        extreset = 1'b0;
        ec = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_clk_sel"}, clk_sel, 1);
        chk({tag, "_phy"}, phy_reset_n, 0);
        chk({tag, "_ad"}, ad9866_rst_n, 0);
        chk({tag, "_rx"}, rx_rst, 3'b111);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_fault"}, clk_fault, 0);
    endtask

    initial begin
        bit seen_r, seen_p;

        // Reset values, then no expansion board: internal clock.
        extreset = 1'b1; pll_locked = 1'b1; exp_present = 1'b0;
        repeat (4) tick();
        chk_reset_vals("rst");
        extreset = 1'b0; ec = 0;
        run_to(9);  chk("s2_clk_sel_e9", clk_sel, 1);
        run_to(22); chk("s2_ready_e22", ready, 0);
        run_to(23); chk("s2_ready_e23", ready, 1);
        chk("s2_clk_sel_e23", clk_sel, 1);

        // Expansion present: external clock, full timeline.
        do_reset(1, 1);
        run_to(8);  chk("s1_clk_sel_e8", clk_sel, 1);
        run_to(9);  chk("s1_clk_sel_e9", clk_sel, 0);
        run_to(12); chk("s1_phy_e12", phy_reset_n, 0);
        run_to(13); chk("s1_phy_e13", phy_reset_n, 1);
        run_to(16); chk("s1_ad_e16", ad9866_rst_n, 0);
        run_to(17); chk("s1_ad_e17", ad9866_rst_n, 1);
        run_to(18); chk("s1_rx_e18", rx_rst, 3'b111);
        run_to(19); chk("s1_rx_e19", rx_rst, 3'b110);
        run_to(21); chk("s1_rx_e21", rx_rst, 3'b100);
        run_to(22); chk("s1_ready_e22", ready, 0);
        run_to(23); chk("s1_rx_e23", rx_rst, 3'b000);
        chk("s1_ready_e23", ready, 1);

        // One-cycle lock drop in S_RUN.
        pll_locked = 1'b0; ec = 0;
        tick();
        pll_locked = 1'b1;
        run_to(2);  chk("s3_ready_e2", ready, 1);
        run_to(3);  chk("s3_ready_e3", ready, 0);
        chk("s3_rx_e3", rx_rst, 3'b111);
        chk("s3_phy_e3", phy_reset_n, 0);
        chk("s3_ad_e3", ad9866_rst_n, 0);
        chk("s3_clk_sel_e3", clk_sel, 0);
        run_to(24); chk("s3_ready_e24", ready, 0);
        run_to(25); chk("s3_ready_e25", ready, 1);
        chk("s3_clk_sel_e25", clk_sel, 0);

        // Expansion removed in S_RUN: restart and reselect internal clock.
        exp_present = 1'b0; ec = 0;
        run_to(2);  chk("s7_ready_e2", ready, 1);
        run_to(3);  chk("s7_ready_e3", ready, 0);
        chk("s7_clk_sel_e3", clk_sel, 0);
        run_to(24); chk("s7_ready_e24", ready, 0);
        run_to(25); chk("s7_ready_e25", ready, 1);
        chk("s7_clk_sel_e25", clk_sel, 1);

        // Lock toggling every 5 cycles never satisfies LOCK_WAIT.
        do_reset(0, 1);
        seen_r = 1'b0; seen_p = 1'b0;
        for (int k = 0; k < 12; k++) begin
            pll_locked = ~pll_locked;
            repeat (5) begin
                tick();
                seen_r |= ready;
                seen_p |= phy_reset_n;
            end
        end
        chk("s4_ready_seen", seen_r, 0);
        chk("s4_phy_seen", phy_reset_n | seen_p, 0);
        chk("s4_clk_sel", clk_sel, 1);

        // extreset pulse in S_RX.
        do_reset(1, 1);
        run_to(19); chk("s5_rx_e19", rx_rst, 3'b110);
        extreset = 1'b1;
        tick();
        chk_reset_vals("s5_rst");
        extreset = 1'b0; ec = 0;
        run_to(12); chk("s5_phy_e12", phy_reset_n, 0);
        run_to(13); chk("s5_phy_e13", phy_reset_n, 1);
        run_to(22); chk("s5_ready_e22", ready, 0);
        run_to(23); chk("s5_ready_e23", ready, 1);
        chk("s5_rx_e23", rx_rst, 3'b000);
        chk("s5_clk_sel_e23", clk_sel, 0);

`ifdef HL_CLKMON_EN
        // Heartbeat stops in S_RUN with the external clock selected.
        hb_run = 1'b0; ec = 0;
        while (!clk_fault && ec < 20) tick();
        chk("s6_fault", clk_fault, 1);
        chk("s6_fault_latency_ok", (ec >= 8 && ec <= 12), 1);
        chk("s6_ready_at_fault", ready, 0);
        ec = 0;
        while (!ready && ec < 60) tick();
        chk("s6_ready_again", ready, 1);
        chk("s6_clk_sel", clk_sel, 1);
        chk("s6_fault_sticky", clk_fault, 1);
`else
        repeat (20) tick();
        chk("no_mon_fault", clk_fault, 0);
        chk("no_mon_ready", ready, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
